// File: rtl/ex_md_stage.sv
// Execute stage: ALU, branch/jump resolution, operand forwarding and an iterative
// radix-2 multiply/divide unit. ALU ops: 0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND 10 PASS2.
module ex_md_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned HIST_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           funct3_ID,
  input  logic                 predict_ID,
  input  logic                 ctrl_md_ID,
  input  logic [3:0]           ctrl_alu_op_ID,
  input  logic                 ctrl_alu_src1_ID,
  input  logic                 ctrl_alu_src2_ID,
  input  logic                 ctrl_jalr_ID,
  input  logic                 ctrl_branch_ID,
  input  logic                 ctrl_reg_write_ID,
  input  logic                 ctrl_mem_r_ID,
  input  logic                 ctrl_mem_w_ID,
  input  logic [1:0]           ctrl_wb_reg_src_ID,
  input  logic [4:0]           rs1_ID,
  input  logic [4:0]           rs2_ID,
  input  logic [4:0]           reg_wb_addr_ID,
  input  logic [XLEN-1:0]      rd1_ID,
  input  logic [XLEN-1:0]      rd2_ID,
  input  logic [XLEN-1:0]      imm_ID,
  input  logic [XLEN-1:0]      pc_ID,
  input  logic [XLEN-1:0]      pc_4_ID,
  input  logic                 ctrl_reg_write_MEM,
  input  logic [4:0]           reg_wb_addr_MEM,
  input  logic [XLEN-1:0]      reg_wb_data,
  output logic                 stall_EX,
  output logic                 pc_change_EX,
  output logic [XLEN-1:0]      pc_nxt_EX,
  output logic                 record_we,
  output logic [HIST_BITS-1:0] record_pc,
  output logic                 record_data,
  output logic [XLEN-1:0]      alu_out_EX,
  output logic [XLEN-1:0]      rd2_EX,
  output logic [XLEN-1:0]      pc_4_EX,
  output logic [4:0]           reg_wb_addr_EX,
  output logic [2:0]           funct3_EX,
  output logic                 ctrl_reg_write_EX,
  output logic                 ctrl_mem_r_EX,
  output logic                 ctrl_mem_w_EX,
  output logic [1:0]           ctrl_wb_reg_src_EX
);
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned SH_W  = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

  md_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2:0]        md_op_q, md_op_d;
  logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic [XLEN-1:0] alu_out_q, alu_out_d, rd2_q, rd2_d, pc_4_q, pc_4_d;
  logic [4:0]      reg_wb_addr_q, reg_wb_addr_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            ctrl_reg_write_q, ctrl_reg_write_d, ctrl_mem_r_q, ctrl_mem_r_d;
  logic            ctrl_mem_w_q, ctrl_mem_w_d;
  logic [1:0]      ctrl_wb_reg_src_q, ctrl_wb_reg_src_d;

  logic            ex_fwd_ok;
  logic [XLEN-1:0] ex_fwd_val, rs1_val, rs2_val, src1, src2, alu_res, br_base, br_sum;
  logic            should_branch, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, quo, rem, md_res;
  logic [2*XLEN-1:0] mul_full;
  logic [XLEN:0]   mul_sum, r_shift, trial;

  // Operand forwarding: x0, then EX/MEM (ALU or pc+4 results), then MEM, then regfile
  always_comb begin
    ex_fwd_ok  = ctrl_reg_write_q && (ctrl_wb_reg_src_q == 2'b00 || ctrl_wb_reg_src_q == 2'b10);
    ex_fwd_val = ctrl_wb_reg_src_q[1] ? pc_4_q : alu_out_q;
    if (rs1_ID == 5'd0)                                       rs1_val = '0;
    else if (ex_fwd_ok && reg_wb_addr_q == rs1_ID)            rs1_val = ex_fwd_val;
    else if (ctrl_reg_write_MEM && reg_wb_addr_MEM == rs1_ID) rs1_val = reg_wb_data;
    else                                                      rs1_val = rd1_ID;
    if (rs2_ID == 5'd0)                                       rs2_val = '0;
    else if (ex_fwd_ok && reg_wb_addr_q == rs2_ID)            rs2_val = ex_fwd_val;
    else if (ctrl_reg_write_MEM && reg_wb_addr_MEM == rs2_ID) rs2_val = reg_wb_data;
    else                                                      rs2_val = rd2_ID;
  end

  always_comb begin
    src1 = ctrl_alu_src1_ID ? pc_ID : rs1_val;
    src2 = ctrl_alu_src2_ID ? imm_ID : rs2_val;
    case (ctrl_alu_op_ID)
      4'd0:    alu_res = src1 + src2;
      4'd1:    alu_res = src1 - src2;
      4'd2:    alu_res = src1 << src2[SH_W-1:0];
      4'd3:    alu_res = XLEN'($signed(src1) < $signed(src2));
      4'd4:    alu_res = XLEN'(src1 < src2);
      4'd5:    alu_res = src1 ^ src2;
      4'd6:    alu_res = src1 >> src2[SH_W-1:0];
      4'd7:    alu_res = $signed(src1) >>> src2[SH_W-1:0];
      4'd8:    alu_res = src1 | src2;
      4'd9:    alu_res = src1 & src2;
      4'd10:   alu_res = src2;
      default: alu_res = '0;
    endcase
  end

  // Branch resolution and redirect target
  always_comb begin
    case (funct3_ID)
      3'b000:  should_branch = (rs1_val == rs2_val);
      3'b001:  should_branch = (rs1_val != rs2_val);
      3'b100:  should_branch = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  should_branch = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  should_branch = (rs1_val < rs2_val);
      3'b111:  should_branch = (rs1_val >= rs2_val);
      default: should_branch = 1'b0;
    endcase
    br_base = ctrl_jalr_ID ? rs1_val : pc_ID;
    br_sum  = br_base + imm_ID;
    if (ctrl_jalr_ID) br_sum[0] = 1'b0;
    pc_nxt_EX    = (ctrl_branch_ID && predict_ID && !should_branch) ? pc_4_ID : br_sum;
    stall_EX     = !rst && ((state_q == IDLE && ctrl_md_ID) || state_q == BUSY);
    pc_change_EX = !stall_EX && ((ctrl_branch_ID && (should_branch ^ predict_ID)) || ctrl_jalr_ID);
    record_we    = ctrl_branch_ID && !stall_EX;
    record_pc    = pc_ID[HIST_BITS+1:2];
    record_data  = should_branch;
  end

  // Mul/div operates on magnitudes; signs are reapplied when the result is taken
  always_comb begin
    a_signed = (funct3_ID == 3'b001) || (funct3_ID == 3'b010) || (funct3_ID == 3'b100) || (funct3_ID == 3'b110);
    b_signed = (funct3_ID == 3'b001) || (funct3_ID == 3'b100) || (funct3_ID == 3'b110);
    a_neg    = a_signed && rs1_val[XLEN-1];
    b_neg    = b_signed && rs2_val[XLEN-1];
    a_mag    = a_neg ? -rs1_val : rs1_val;
    b_mag    = b_neg ? -rs2_val : rs2_val;
    mul_full = q_neg_q ? -acc_q : acc_q;
    quo      = q_neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = r_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (md_op_q[2])              md_res = md_op_q[1] ? rem : quo;
    else if (md_op_q[1:0] == 2'b00) md_res = mul_full[XLEN-1:0];
    else                         md_res = mul_full[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    md_op_d = md_op_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    mul_sum = '0;
    r_shift = '0;
    trial   = '0;
    case (state_q)
      IDLE: if (ctrl_md_ID) begin
        state_d = BUSY;
        cnt_d   = CNT_W'(XLEN);
        acc_d   = {{XLEN{1'b0}}, a_mag};
        mcand_d = b_mag;
        md_op_d = funct3_ID;
        // A zero divisor keeps the all-ones quotient unsigned
        q_neg_d = (a_neg ^ b_neg) && !(funct3_ID[2] && rs2_val == '0);
        r_neg_d = a_neg;
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
        if (!md_op_q[2]) begin
          mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
          acc_d   = {mul_sum, acc_q[XLEN-1:1]};
        end else begin
          r_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
          trial   = r_shift - {1'b0, mcand_q};
          acc_d   = trial[XLEN] ? {r_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // EX/MEM register; stalled cycles insert a bubble
  always_comb begin
    alu_out_d         = (state_q == DONE) ? md_res : alu_res;
    rd2_d             = rs2_val;
    pc_4_d            = pc_4_ID;
    reg_wb_addr_d     = reg_wb_addr_ID;
    funct3_d          = funct3_ID;
    ctrl_wb_reg_src_d = ctrl_wb_reg_src_ID;
    ctrl_reg_write_d  = ctrl_reg_write_ID && !stall_EX;
    ctrl_mem_r_d      = ctrl_mem_r_ID && !stall_EX;
    ctrl_mem_w_d      = ctrl_mem_w_ID && !stall_EX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;  cnt_q <= '0;  acc_q <= '0;  mcand_q <= '0;
      md_op_q <= '0;  q_neg_q <= 1'b0;  r_neg_q <= 1'b0;
      alu_out_q <= '0;  rd2_q <= '0;  pc_4_q <= '0;  reg_wb_addr_q <= '0;
      funct3_q <= '0;  ctrl_reg_write_q <= 1'b0;  ctrl_mem_r_q <= 1'b0;
      ctrl_mem_w_q <= 1'b0;  ctrl_wb_reg_src_q <= '0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  acc_q <= acc_d;  mcand_q <= mcand_d;
      md_op_q <= md_op_d;  q_neg_q <= q_neg_d;  r_neg_q <= r_neg_d;
      alu_out_q <= alu_out_d;  rd2_q <= rd2_d;  pc_4_q <= pc_4_d;
      reg_wb_addr_q <= reg_wb_addr_d;  funct3_q <= funct3_d;
      ctrl_reg_write_q <= ctrl_reg_write_d;  ctrl_mem_r_q <= ctrl_mem_r_d;
      ctrl_mem_w_q <= ctrl_mem_w_d;  ctrl_wb_reg_src_q <= ctrl_wb_reg_src_d;
    end
  end

  assign alu_out_EX         = alu_out_q;
  assign rd2_EX             = rd2_q;
  assign pc_4_EX            = pc_4_q;
  assign reg_wb_addr_EX     = reg_wb_addr_q;
  assign funct3_EX          = funct3_q;
  assign ctrl_reg_write_EX  = ctrl_reg_write_q;
  assign ctrl_mem_r_EX      = ctrl_mem_r_q;
  assign ctrl_mem_w_EX      = ctrl_mem_w_q;
  assign ctrl_wb_reg_src_EX = ctrl_wb_reg_src_q;
endmodule

// File: doc/ex_md_stage.md
EX_MD_STAGE -- requirements
Module: ex_md_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (legal values 32 and 64).
REQ-002 SHALL have parameter HIST_BITS, default 5, width of record_pc.
REQ-003 SHALL have ports, name / direction / width / meaning:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- funct3_ID  in  3  branch condition, or M-extension op (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- predict_ID  in  1  fetch predicted taken.
- ctrl_md_ID  in  1  M-extension instruction.
- ctrl_alu_op_ID  in  4  ALU operation.
- ctrl_alu_src1_ID / ctrl_alu_src2_ID  in  1 each  select pc_ID / imm_ID.
- ctrl_jalr_ID, ctrl_branch_ID  in  1 each  jalr / conditional branch.
- ctrl_reg_write_ID, ctrl_mem_r_ID, ctrl_mem_w_ID  in  1 each  pass-through controls.
- ctrl_wb_reg_src_ID  in  2  00 ALU/MD, 01 memory, 10 pc+4.
- rs1_ID, rs2_ID, reg_wb_addr_ID  in  5 each  register addresses.
- rd1_ID, rd2_ID, imm_ID, pc_ID, pc_4_ID  in  XLEN each  operands.
- ctrl_reg_write_MEM  in  1, reg_wb_addr_MEM  in  5, reg_wb_data  in  XLEN  MEM-stage forwarding source.
- stall_EX  out  1  ID must hold its register contents and fetch must freeze.
- pc_change_EX  out  1, pc_nxt_EX  out  XLEN  redirect.
- record_we  out  1, record_pc  out  HIST_BITS, record_data  out  1  branch history update.
- alu_out_EX, rd2_EX, pc_4_EX  out  XLEN; reg_wb_addr_EX  out  5; funct3_EX  out  3; ctrl_reg_write_EX, ctrl_mem_r_EX, ctrl_mem_w_EX  out  1; ctrl_wb_reg_src_EX  out  2  EX/MEM register.

Function
REQ-004 SHALL forward operands with priority: x0 -> 0; else EX/MEM match with wb_src 00 (alu_out_EX) or 10 (pc_4_EX); else MEM match (reg_wb_data); else register value.
REQ-005 SHALL resolve branches as in the single-cycle EX path: should_branch from funct3 (EQ/NE, LT/GE, LTU/GEU); pc_change_EX = (ctrl_branch_ID & (should_branch ^ predict_ID)) | ctrl_jalr_ID.
REQ-006 SHALL drive pc_nxt_EX = pc_4_ID on predicted-taken-not-taken, else (jalr ? rs1 : pc_ID) + imm_ID, jalr sum with bit 0 cleared.
REQ-007 SHALL drive record_we = ctrl_branch_ID & ~stall_EX, record_pc = pc_ID[HIST_BITS+1:2], record_data = should_branch.
REQ-008 SHALL include a mul/div FSM with states IDLE, BUSY, DONE and an iteration counter of clog2(XLEN)+1 bits.
REQ-009 IDLE -> BUSY when ctrl_md_ID=1: latch forwarded operands and funct3, load counter with XLEN.
REQ-010 In BUSY, SHALL perform one radix-2 step (shift-add multiply or restoring divide) per cycle and decrement the counter; BUSY -> DONE when counter reaches 1.
REQ-011 DONE -> IDLE unconditionally; in DONE the EX/MEM register captures the MD result with the ID-stage controls.
REQ-012 stall_EX SHALL be 1 in the IDLE cycle where an MD op starts and in every BUSY cycle, and 0 in DONE; stall duration is exactly XLEN+1 cycles.
REQ-013 While stall_EX=1, the EX/MEM register SHALL load a bubble (reg_write, mem_r, mem_w = 0); pc_change_EX and record_we SHALL be 0.
REQ-014 MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits of the signed*signed / signed*unsigned / unsigned*unsigned 2*XLEN product.
REQ-015 Divide by zero: quotient all ones, remainder = dividend. Signed overflow (min / -1): quotient = min, remainder = 0. Latency is unchanged in both cases.
REQ-016 Non-MD instructions SHALL register in one cycle with no stall.

Reset
REQ-017 rst SHALL force the FSM to IDLE, the counter to 0, and all registered outputs to 0, including a reset asserted during BUSY (the MD result is discarded).
REQ-018 During rst, stall_EX SHALL be 0.

Verification
REQ-019 XLEN=32, DIV 7 / -2 -> stall_EX high for 33 cycles; then alu_out_EX = 0xFFFFFFFD; REM gives 1.
REQ-020 MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MUL gives 0x00000001.
REQ-021 DIVU x / 0 -> 0xFFFFFFFF; DIV 0x80000000 / -1 -> 0x80000000, REM -> 0.
REQ-022 BEQ equal operands, predict_ID=0, pc_ID=0x100, imm=0x20 -> pc_change_EX=1, pc_nxt_EX=0x120, record_data=1.
REQ-023 ADD writing x5 followed by a dependent MUL on x5 -> the MUL uses the forwarded alu_out_EX value.
REQ-024 rst pulsed mid-BUSY -> next cycle stall_EX=0, all outputs 0; the next MD op completes correctly.
